quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature decoder for the Segway wheel encoders. It synchronizes and de-glitches the asynchronous encoder channels A and B and decodes each legal Gray-code transition into a +1/-1 step. It keeps a wrapping position count and flags illegal transitions. It drives the direction and enable information that the up/down position counter path consumes, i.e. the producing end of that interface.

## Interface
- CNT_W, 16, width of position count (two's complement, wraps)
- FILT, 2, consecutive identical synchronized samples required before a channel level is accepted (≥1)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- A  in  1  encoder channel A, asynchronous
- B  in  1  encoder channel B, asynchronous
- en  in  1  1 = steps update cnt; 0 = phase still tracked, cnt frozen, step/dir still reported
- clr  in  1  synchronous clear of cnt to 0
- err_clr  in  1  clears sticky err
- cnt  out  CNT_W  signed position count
- step  out  1  one-cycle pulse per decoded legal transition
- dir  out  1  direction of last legal step: 1 = up (forward), 0 = down
- err  out  1  sticky: illegal (double) transition seen

## Operation
- Per channel: 2-flop synchronizer, then glitch filter. The filtered level changes only after FILT consecutive synchronized samples equal the new value. Shorter pulses are discarded entirely.
- Phase = {A_f, B_f}. Forward order is 00→01→11→10→00. Each forward transition = +1, reverse = −1 (4x decoding).
- State machine:
  - INIT (after rst): first cycle's filtered phase is loaded as the current phase; no step; → TRACK.
  - TRACK: on filtered phase change, classify as forward, reverse, or illegal (both bits changed).
- Legal step: step=1 for one cycle, dir updated. cnt += ±1 if en=1 (modulo 2^CNT_W: 0x7FFF+1 → 0x8000, 0x0000−1 → 0xFFFF).
- Illegal transition: no step, dir and cnt unchanged, err set, phase updated to new value.
- No phase change: step=0, all else held.
- clr and a step in the same cycle: clr wins, cnt=0, step and dir still reported.
- err_clr and illegal transition in the same cycle: err stays 1 (set wins).
- en=0 does not suppress step/dir/err.

## Timing
- Reset values: cnt=0, step=0, dir=1, err=0, state=INIT, filter histories and synchronizers cleared to 0.
- Latency: A/B stable before rising edge N → step/dir/cnt updated at edge N+2+FILT (FILT=2: 4 edges).
- clr, err_clr, en are registered-effect: act on the edge where they are sampled high.
- Max legal input rate: one phase change per FILT+1 cycles. Faster inputs are filtered out or reported as illegal; never miscounted silently.
- rst mid-operation: all outputs return to reset values on that edge. Next filtered phase reloads via INIT without stepping.

## Structure
- Package quad_pkg: enum phase_t {PH00, PH01, PH11, PH10}, enum state_t {INIT, TRACK}, localparams DIR_UP=1, DIR_DN=0.
- Sub-module quad_filt: synchronizer + FILT glitch filter for one channel, instantiated twice (A, B).
- Top: phase register, INIT/TRACK FSM, transition classifier, cnt/err registers.

## Test plan
- Reset, A=B=0 held, en=1 → cnt=0, dir=1, err=0, step never asserted.
- Four forward transitions (00→01→11→10→00), each held 8 cycles → four step pulses, cnt=4, dir=1, each 4 edges after input change.
- Then two reverse transitions → cnt=2, dir=0. Apply clr on the same cycle as the next step → cnt=0, step=1.
- 1-cycle glitch on A (FILT=2) → no step, cnt unchanged.
- Illegal 00→11 jump → err=1, cnt unchanged, no step. err_clr → err=0. en=0 with 3 forward steps → 3 step pulses, cnt unchanged.
- Preload cnt=0xFFFF via 1 reverse step from 0, then forward step → cnt=0x0000. Assert rst mid-sequence → all outputs at reset values, next phase change after INIT counts normally.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg
//   Shared types and constants for the quadrature decoder.
//   phase_t : filtered {A,B} level pair, encoded as the raw bit pair.
//   state_t : INIT/TRACK decoder state.
//   phase_fwd() returns the forward (count-up) successor of a phase.
package quad_pkg;

  typedef enum logic [1:0] {
    PH00 = 2'b00,
    PH01 = 2'b01,
    PH11 = 2'b11,
    PH10 = 2'b10
  } phase_t;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic phase_t phase_fwd(input phase_t p);
    phase_t n;
    case (p)
      PH00:    n = PH01;
      PH01:    n = PH11;
      PH11:    n = PH10;
      default: n = PH00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_filt.sv
// quad_filt
//   Two-flop synchronizer followed by a glitch filter for one encoder channel.
//   The filtered level only moves to a new value after FILT consecutive
//   synchronized samples have shown that value; shorter pulses vanish.
// Ports
//   i_clk : system clock
//   i_rst : synchronous active-high reset (clears synchronizer and level)
//   i_d   : asynchronous channel input
//   o_q   : filtered, synchronous channel level
module quad_filt #(
  parameter int FILT = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  localparam int TW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(FILT - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_q;
  logic [TW-1:0] r_tmr;

  // r_tmr counts down the remaining disagreeing samples; any sample that
  // agrees with the current level restarts the run from the top.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_q   <= 1'b0;
      r_tmr <= RELOAD;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      if (r_s2 == r_q) begin
        r_tmr <= RELOAD;
      end else if (r_tmr == '0) begin
        r_q   <= r_s2;
        r_tmr <= RELOAD;
      end else begin
        r_tmr <= r_tmr - TW'(1);
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder
//   Quadrature decoder: filters encoder channels A/B, decodes each legal
//   Gray-code transition into a +1/-1 step, keeps a wrapping position count
//   and flags illegal (double-bit) transitions.
//
//   state | meaning
//   INIT  | first cycle after reset: adopt filtered phase, never step
//   TRACK | compare filtered phase to stored phase, classify changes
//
// Ports
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_a, i_b       : asynchronous encoder channels
//   i_en           : 1 = steps update count, 0 = count frozen
//   i_clr          : clear count (wins over a simultaneous step)
//   i_err_clr      : clear sticky error (loses to a simultaneous illegal edge)
//   o_cnt          : signed wrapping position count
//   o_step         : one-cycle pulse per legal transition
//   o_dir          : direction of last legal step (1 = up)
//   o_err          : sticky illegal-transition flag
import quad_pkg::*;

module quad_decoder #(
  parameter int CNT_W = 16,
  parameter int FILT  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_a,
  input  logic                    i_b,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic                    i_err_clr,
  output logic signed [CNT_W-1:0] o_cnt,
  output logic                    o_step,
  output logic                    o_dir,
  output logic                    o_err
);

  logic   w_a_f;
  logic   w_b_f;
  phase_t w_ph;
  logic   w_chg;
  logic   w_fwd;
  logic   w_rev;
  logic   w_ill;

  state_t           r_state;
  phase_t           r_ph;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step;
  logic             r_dir;
  logic             r_err;

  quad_filt #(.FILT(FILT)) u_filt_a (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_a),
    .o_q   (w_a_f)
  );

  quad_filt #(.FILT(FILT)) u_filt_b (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_b),
    .o_q   (w_b_f)
  );

  assign w_ph  = phase_t'({w_a_f, w_b_f});
  assign w_chg = (r_state == TRACK) && (w_ph != r_ph);
  assign w_fwd = w_chg && (w_ph == phase_fwd(r_ph));
  // Reverse step: the old phase is the forward successor of the new one.
  assign w_rev = w_chg && (r_ph == phase_fwd(w_ph));
  assign w_ill = w_chg && !w_fwd && !w_rev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INIT;
      r_ph    <= PH00;
      r_cnt   <= '0;
      r_step  <= 1'b0;
      r_dir   <= DIR_UP;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_ph    <= w_ph;
          r_state <= TRACK;
        end
        default: begin
          r_ph    <= w_ph;
          r_state <= TRACK;
        end
      endcase

      r_step <= w_fwd | w_rev;

      if (w_fwd) begin
        r_dir <= DIR_UP;
      end else if (w_rev) begin
        r_dir <= DIR_DN;
      end

      if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en && w_fwd) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_en && w_rev) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_ill) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_cnt  = r_cnt;
  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
module tb_quad_decoder;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_a = 1'b0;
  logic               i_b = 1'b0;
  logic               i_en = 1'b1;
  logic               i_clr = 1'b0;
  logic               i_err_clr = 1'b0;
  logic signed [15:0] o_cnt;
  logic               o_step;
  logic               o_dir;
  logic               o_err;

  int n_vec = 0;
  int n_miss = 0;

  quad_decoder #(.CNT_W(16), .FILT(2)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_en      (i_en),
    .i_clr     (i_clr),
    .i_err_clr (i_err_clr),
    .o_cnt     (o_cnt),
    .o_step    (o_step),
    .o_dir     (o_dir),
    .o_err     (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Apply a new phase and hold it 8 cycles. A legal change must show its
  // pulse on exactly the 5th sampled edge (4 edges after the one that first
  // sees the input). clr/err_clr can be raised for that same edge.
  task automatic move(input string tag, input logic a, input logic b,
                      input int exp_pulses, input bit clr_at, input bit ec_at);
    int pulses;
    pulses = 0;
    i_a = a;
    i_b = b;
    for (int k = 1; k <= 8; k++) begin
      if (k == 5) begin
        i_clr     = clr_at;
        i_err_clr = ec_at;
      end
      tick();
      if (k == 5) begin
        chk({tag, "_step_lat"}, {31'd0, o_step}, exp_pulses[31:0]);
        i_clr     = 1'b0;
        i_err_clr = 1'b0;
      end
      if (o_step) pulses++;
    end
    chk({tag, "_pulses"}, pulses, exp_pulses);
  endtask

  task automatic chk_state(input string tag, input logic [15:0] cnt,
                           input logic dir, input logic err);
    chk({tag, "_cnt"}, {16'd0, o_cnt}, {16'd0, cnt});
    chk({tag, "_dir"}, {31'd0, o_dir}, {31'd0, dir});
    chk({tag, "_err"}, {31'd0, o_err}, {31'd0, err});
  endtask

  initial begin
    int pulses;

    // Reset with A=B=0
    repeat (3) tick();
    chk_state("rst", 16'h0000, 1'b1, 1'b0);
    chk("rst_step", {31'd0, o_step}, 32'd0);
    i_rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_step) pulses++;
    end
    chk("idle_pulses", pulses, 0);
    chk_state("idle", 16'h0000, 1'b1, 1'b0);

    // Four forward steps
    move("f1", 1'b0, 1'b1, 1, 1'b0, 1'b0);
    move("f2", 1'b1, 1'b1, 1, 1'b0, 1'b0);
    move("f3", 1'b1, 1'b0, 1, 1'b0, 1'b0);
    move("f4", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    chk_state("fwd4", 16'd4, 1'b1, 1'b0);

    // Two reverse steps: 00 -> 10 -> 11
    move("r1", 1'b1, 1'b0, 1, 1'b0, 1'b0);
    move("r2", 1'b1, 1'b1, 1, 1'b0, 1'b0);
    chk_state("rev2", 16'd2, 1'b0, 1'b0);

    // Reverse 11 -> 01 with clr on the step edge
    move("rclr", 1'b0, 1'b1, 1, 1'b1, 1'b0);
    chk_state("clr_step", 16'd0, 1'b0, 1'b0);

    // One-cycle glitch on A while at phase 01
    i_a = 1'b1;
    tick();
    i_a = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_step) pulses++;
    end
    chk("glitch_pulses", pulses, 0);
    chk_state("glitch", 16'd0, 1'b0, 1'b0);

    // Forward back to 00: 01 -> 11 -> 10 -> 00
    move("g1", 1'b1, 1'b1, 1, 1'b0, 1'b0);
    move("g2", 1'b1, 1'b0, 1, 1'b0, 1'b0);
    move("g3", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    chk_state("back00", 16'd3, 1'b1, 1'b0);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("clr_alone", {16'd0, o_cnt}, 32'd0);

    // Illegal 00 -> 11
    move("ill", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    chk_state("ill", 16'd0, 1'b1, 1'b1);
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    chk("err_clr", {31'd0, o_err}, 32'd0);

    // en=0: 11 -> 10 -> 00 -> 01, count frozen
    i_en = 1'b0;
    move("e1", 1'b1, 1'b0, 1, 1'b0, 1'b0);
    move("e2", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    move("e3", 1'b0, 1'b1, 1, 1'b0, 1'b0);
    chk_state("en0", 16'd0, 1'b1, 1'b0);
    i_en = 1'b1;

    // Wrap: 01 -> 00 gives 0xFFFF, then 00 -> 01 gives 0
    move("w1", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    chk_state("wrap_dn", 16'hFFFF, 1'b0, 1'b0);
    move("w2", 1'b0, 1'b1, 1, 1'b0, 1'b0);
    chk_state("wrap_up", 16'h0000, 1'b1, 1'b0);

    // Illegal 01 -> 10 with err_clr on the same edge: set wins
    move("illc", 1'b1, 1'b0, 0, 1'b0, 1'b1);
    chk_state("ill_vs_clr", 16'h0000, 1'b1, 1'b1);

    // Reverse 10 -> 11 -> 01 -> 00 to leave dir=0, cnt=-3
    move("x1", 1'b1, 1'b1, 1, 1'b0, 1'b0);
    move("x2", 1'b0, 1'b1, 1, 1'b0, 1'b0);
    move("x3", 1'b0, 1'b0, 1, 1'b0, 1'b0);
    chk_state("pre_rst", 16'hFFFD, 1'b0, 1'b1);

    // Mid-run reset, then normal counting
    i_rst = 1'b1;
    tick();
    chk_state("mid_rst", 16'h0000, 1'b1, 1'b0);
    chk("mid_rst_step", {31'd0, o_step}, 32'd0);
    i_rst = 1'b0;
    tick();
    tick();
    move("post", 1'b0, 1'b1, 1, 1'b0, 1'b0);
    chk_state("post_rst", 16'd1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
